// File: rtl/mips_pipelined.sv
// Five-stage (IF, ID, EX, MEM, WB) pipelined MIPS subset core with internal instruction
// memory, data memory and register file. The environment preloads InstrMem/DatMem/RegFile
// through hierarchical references before releasing reset.
//
// Ports:
//   clk  - system clock, all state updates on the rising edge
//   rst  - synchronous active-high reset
`timescale 1ns / 1ps

module mips_pipelined (
    input logic clk,
    input logic rst
);

    typedef enum logic [2:0] {
        AluAdd, AluSub, AluAnd, AluOr, AluSlt, AluSll, AluHi, AluLo
    } alu_op_e;

    // All-zero control word is a NOP: dst of 0 means no register write.
    typedef struct packed {
        logic [4:0] dst;
        alu_op_e    alu_op;
        logic       use_imm;
        logic       mem_read;
        logic       mem_write;
        logic       beq;
        logic       bne;
        logic       multu;
    } ctrl_t;

    // ------------------------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------------------------
    logic [31:0] pc;
    logic [31:0] ifid_instr_q, ifid_pc4_q;

    ctrl_t       idex_ctrl_q;
    logic [31:0] idex_rs_val_q, idex_rt_val_q, idex_imm_q, idex_pc4_q;
    logic [4:0]  idex_rs_q, idex_rt_q, idex_shamt_q;

    ctrl_t       exmem_ctrl_q;
    logic [31:0] exmem_alu_q, exmem_store_q;

    ctrl_t       memwb_ctrl_q;
    logic [31:0] memwb_alu_q, memwb_load_q;

    logic [31:0] hi_q, lo_q;

    logic [31:0] rfile_wd;

    // ------------------------------------------------------------------------------------
    // Storage arrays, scoped so that InstrMem.mem_array etc. are reachable by name
    // ------------------------------------------------------------------------------------
    if (1) begin : InstrMem
        logic [7:0] mem_array [1024];
    end

    logic [9:0] mem_addr;
    assign mem_addr = {exmem_alu_q[9:2], 2'b00};

    if (1) begin : DatMem
        logic [7:0] mem_array [1024];
        always_ff @(posedge clk) begin
            if (!rst && exmem_ctrl_q.mem_write) begin
                mem_array[mem_addr]         <= exmem_store_q[7:0];
                mem_array[mem_addr + 10'd1] <= exmem_store_q[15:8];
                mem_array[mem_addr + 10'd2] <= exmem_store_q[23:16];
                mem_array[mem_addr + 10'd3] <= exmem_store_q[31:24];
            end
        end
    end

    if (1) begin : RegFile
        logic [31:0] file_array [32];
        always_ff @(posedge clk) begin
            if (!rst && memwb_ctrl_q.dst != 5'd0) begin
                file_array[memwb_ctrl_q.dst] <= rfile_wd;
            end
        end
    end

    // ------------------------------------------------------------------------------------
    // IF
    // ------------------------------------------------------------------------------------
    logic [9:0]  fetch_addr;
    logic [31:0] instr_if;
    assign fetch_addr = {pc[9:2], 2'b00};
    assign instr_if   = {InstrMem.mem_array[fetch_addr + 10'd3],
                         InstrMem.mem_array[fetch_addr + 10'd2],
                         InstrMem.mem_array[fetch_addr + 10'd1],
                         InstrMem.mem_array[fetch_addr]};

    // ------------------------------------------------------------------------------------
    // ID
    // ------------------------------------------------------------------------------------
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] imm_ext, j_target, rs_val, rt_val;
    logic        is_jump, load_use;
    ctrl_t       ctrl_id;

    assign opcode   = ifid_instr_q[31:26];
    assign rs       = ifid_instr_q[25:21];
    assign rt       = ifid_instr_q[20:16];
    assign rd       = ifid_instr_q[15:11];
    assign shamt    = ifid_instr_q[10:6];
    assign funct    = ifid_instr_q[5:0];
    assign imm_ext  = {{16{ifid_instr_q[15]}}, ifid_instr_q[15:0]};
    assign j_target = {ifid_pc4_q[31:28], ifid_instr_q[25:0], 2'b00};
    assign is_jump  = (opcode == 6'd2);

    // Same-cycle WB value bypasses the array read (write-before-read).
    assign rs_val = (rs == 5'd0) ? 32'd0 :
                    (memwb_ctrl_q.dst == rs) ? rfile_wd : RegFile.file_array[rs];
    assign rt_val = (rt == 5'd0) ? 32'd0 :
                    (memwb_ctrl_q.dst == rt) ? rfile_wd : RegFile.file_array[rt];

    always_comb begin
        ctrl_id = '0;
        case (opcode)
            6'd0: begin
                case (funct)
                    6'd32: begin ctrl_id.dst = rd; ctrl_id.alu_op = AluAdd; end
                    6'd34: begin ctrl_id.dst = rd; ctrl_id.alu_op = AluSub; end
                    6'd36: begin ctrl_id.dst = rd; ctrl_id.alu_op = AluAnd; end
                    6'd37: begin ctrl_id.dst = rd; ctrl_id.alu_op = AluOr;  end
                    6'd42: begin ctrl_id.dst = rd; ctrl_id.alu_op = AluSlt; end
                    6'd0:  begin ctrl_id.dst = rd; ctrl_id.alu_op = AluSll; end
                    6'd10: begin ctrl_id.dst = rd; ctrl_id.alu_op = AluHi;  end
                    6'd12: begin ctrl_id.dst = rd; ctrl_id.alu_op = AluLo;  end
                    6'd25: ctrl_id.multu = 1'b1;
                    default: ctrl_id = '0;
                endcase
            end
            6'd9: begin
                ctrl_id.dst     = rt;
                ctrl_id.use_imm = 1'b1;
            end
            6'd35: begin
                ctrl_id.dst      = rt;
                ctrl_id.use_imm  = 1'b1;
                ctrl_id.mem_read = 1'b1;
            end
            6'd43: begin
                ctrl_id.use_imm   = 1'b1;
                ctrl_id.mem_write = 1'b1;
            end
            6'd4:    ctrl_id.beq = 1'b1;
            6'd5:    ctrl_id.bne = 1'b1;
            default: ctrl_id = '0;
        endcase
    end

    // A load to $0 writes nothing, so it cannot create a hazard.
    assign load_use = idex_ctrl_q.mem_read && (idex_ctrl_q.dst != 5'd0) &&
                      ((idex_ctrl_q.dst == rs) || (idex_ctrl_q.dst == rt));

    // ------------------------------------------------------------------------------------
    // EX
    // ------------------------------------------------------------------------------------
    logic [31:0] fwd_a, fwd_b, op_b, alu_res, br_target;
    logic [63:0] product;
    logic        br_taken;

    always_comb begin
        fwd_a = idex_rs_val_q;
        if (exmem_ctrl_q.dst != 5'd0 && exmem_ctrl_q.dst == idex_rs_q) begin
            fwd_a = exmem_alu_q;
        end else if (memwb_ctrl_q.dst != 5'd0 && memwb_ctrl_q.dst == idex_rs_q) begin
            fwd_a = rfile_wd;
        end
        fwd_b = idex_rt_val_q;
        if (exmem_ctrl_q.dst != 5'd0 && exmem_ctrl_q.dst == idex_rt_q) begin
            fwd_b = exmem_alu_q;
        end else if (memwb_ctrl_q.dst != 5'd0 && memwb_ctrl_q.dst == idex_rt_q) begin
            fwd_b = rfile_wd;
        end
    end

    assign op_b      = idex_ctrl_q.use_imm ? idex_imm_q : fwd_b;
    assign product   = {32'd0, fwd_a} * {32'd0, fwd_b};
    assign br_target = idex_pc4_q + {idex_imm_q[29:0], 2'b00};
    assign br_taken  = (idex_ctrl_q.beq && (fwd_a == fwd_b)) ||
                       (idex_ctrl_q.bne && (fwd_a != fwd_b));

    always_comb begin
        alu_res = 32'd0;
        case (idex_ctrl_q.alu_op)
            AluAdd:  alu_res = fwd_a + op_b;
            AluSub:  alu_res = fwd_a - op_b;
            AluAnd:  alu_res = fwd_a & op_b;
            AluOr:   alu_res = fwd_a | op_b;
            AluSlt:  alu_res = {31'd0, $signed(fwd_a) < $signed(op_b)};
            AluSll:  alu_res = fwd_b << idex_shamt_q;
            AluHi:   alu_res = hi_q;
            AluLo:   alu_res = lo_q;
            default: alu_res = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------------------------
    // MEM / WB
    // ------------------------------------------------------------------------------------
    logic [31:0] load_data;
    assign load_data = {DatMem.mem_array[mem_addr + 10'd3], DatMem.mem_array[mem_addr + 10'd2],
                        DatMem.mem_array[mem_addr + 10'd1], DatMem.mem_array[mem_addr]};
    assign rfile_wd  = memwb_ctrl_q.mem_read ? memwb_load_q : memwb_alu_q;

    // ------------------------------------------------------------------------------------
    // Sequential pipeline update. Priority: taken branch > load-use stall > jump.
    // ------------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= 32'd0;
            hi_q          <= 32'd0;
            lo_q          <= 32'd0;
            ifid_instr_q  <= 32'd0;
            ifid_pc4_q    <= 32'd0;
            idex_ctrl_q   <= '0;
            idex_rs_val_q <= 32'd0;
            idex_rt_val_q <= 32'd0;
            idex_imm_q    <= 32'd0;
            idex_pc4_q    <= 32'd0;
            idex_rs_q     <= 5'd0;
            idex_rt_q     <= 5'd0;
            idex_shamt_q  <= 5'd0;
            exmem_ctrl_q  <= '0;
            exmem_alu_q   <= 32'd0;
            exmem_store_q <= 32'd0;
            memwb_ctrl_q  <= '0;
            memwb_alu_q   <= 32'd0;
            memwb_load_q  <= 32'd0;
        end else begin
            exmem_ctrl_q  <= idex_ctrl_q;
            exmem_alu_q   <= alu_res;
            exmem_store_q <= fwd_b;
            memwb_ctrl_q  <= exmem_ctrl_q;
            memwb_alu_q   <= exmem_alu_q;
            memwb_load_q  <= load_data;
            if (idex_ctrl_q.multu) begin
                hi_q <= product[63:32];
                lo_q <= product[31:0];
            end

            if (br_taken) begin
                pc           <= br_target;
                ifid_instr_q <= 32'd0;
                idex_ctrl_q  <= '0;
            end else if (load_use) begin
                idex_ctrl_q  <= '0;
            end else begin
                idex_ctrl_q   <= ctrl_id;
                idex_rs_val_q <= rs_val;
                idex_rt_val_q <= rt_val;
                idex_imm_q    <= imm_ext;
                idex_pc4_q    <= ifid_pc4_q;
                idex_rs_q     <= rs;
                idex_rt_q     <= rt;
                idex_shamt_q  <= shamt;
                if (is_jump) begin
                    pc           <= j_target;
                    ifid_instr_q <= 32'd0;
                end else begin
                    pc           <= pc + 32'd4;
                    ifid_instr_q <= instr_if;
                    ifid_pc4_q   <= pc + 32'd4;
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_pipelined.sv
// Directed testbench for mips_pipelined: preloads a program, traces pc / rfile_wd per cycle
// after reset release, then checks pipeline timing and final architectural state.
`timescale 1ns / 1ps

module tb_mips_pipelined;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] pc_tr [48];
    logic [31:0] wd_tr [48];

    mips_pipelined dut (
        .clk (clk),
        .rst (rst)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] r_type(input logic [4:0] rs_f, input logic [4:0] rt_f,
                                           input logic [4:0] rd_f, input logic [4:0] sh,
                                           input logic [5:0] fn);
        return {6'd0, rs_f, rt_f, rd_f, sh, fn};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs_f,
                                           input logic [4:0] rt_f, input logic [15:0] imm);
        return {op, rs_f, rt_f, imm};
    endfunction

    function automatic logic [31:0] j_type(input logic [31:0] target);
        return {6'd2, target[27:2]};
    endfunction

    task automatic put(input int addr, input logic [31:0] w);
        dut.InstrMem.mem_array[addr]     = w[7:0];
        dut.InstrMem.mem_array[addr + 1] = w[15:8];
        dut.InstrMem.mem_array[addr + 2] = w[23:16];
        dut.InstrMem.mem_array[addr + 3] = w[31:24];
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) dut.InstrMem.mem_array[i] = 8'h00;
        put('h00, i_type(9, 0, 8, 16'h0033));    // ADDIU $8,$0,0x33
        put('h04, j_type(32'h40));               // J 0x40
        put('h08, i_type(9, 0, 8, 16'h0003));    // flushed by J
        put('h40, i_type(9, 0, 1, 16'd5));       // ADDIU $1,$0,5
        put('h44, i_type(9, 0, 2, 16'd7));       // ADDIU $2,$0,7
        put('h48, r_type(1, 2, 3, 0, 32));       // ADD $3,$1,$2
        put('h4C, i_type(9, 0, 20, 16'd10));     // ADDIU $20,$0,10
        put('h50, i_type(43, 0, 20, 16'd8));     // SW $20,8($0)
        put('h54, i_type(35, 0, 4, 16'd8));      // LW $4,8($0)
        put('h58, r_type(4, 4, 5, 0, 32));       // ADD $5,$4,$4 (load-use)
        put('h5C, i_type(9, 0, 6, 16'h1234));    // ADDIU $6,$0,0x1234
        put('h60, i_type(43, 0, 6, 16'd16));     // SW $6,16($0)
        put('h64, i_type(35, 0, 7, 16'd16));     // LW $7,16($0)
        put('h68, i_type(4, 0, 0, 16'd2));       // BEQ $0,$0,+2
        put('h6C, i_type(9, 0, 8, 16'd1));       // flushed
        put('h70, i_type(9, 0, 8, 16'd2));       // flushed
        put('h74, i_type(9, 0, 9, 16'd1));       // ADDIU $9,$0,1
        put('h78, i_type(5, 0, 0, 16'd2));       // BNE $0,$0,+2 (not taken)
        put('h7C, i_type(9, 0, 14, 16'h0077));   // ADDIU $14,$0,0x77
        put('h80, i_type(9, 0, 1, 16'hFFFF));    // ADDIU $1,$0,-1
        put('h84, i_type(9, 0, 2, 16'd2));       // ADDIU $2,$0,2
        put('h88, r_type(1, 2, 0, 0, 25));       // MULTU $1,$2
        put('h8C, r_type(0, 0, 10, 0, 10));      // MFHI $10
        put('h90, r_type(0, 0, 11, 0, 12));      // MFLO $11
        put('h94, r_type(1, 2, 12, 0, 42));      // SLT $12,$1,$2
        put('h98, r_type(0, 2, 13, 3, 0));       // SLL $13,$2,3
        put('h9C, i_type(9, 0, 15, 16'h0055));   // ADDIU $15,$0,0x55
        put('hA0, r_type(1, 2, 15, 0, 63));      // unknown funct -> NOP
        put('hA4, i_type(63, 0, 15, 16'd5));     // unknown opcode -> NOP
        put('hA8, j_type(32'hA8));               // J self

        repeat (3) @(posedge clk);
        #1;
        check("reset_pc", dut.pc, 32'h0);
        rst = 1'b0;
        pc_tr[0] = dut.pc;
        wd_tr[0] = dut.rfile_wd;
        for (int k = 1; k < 48; k++) begin
            @(posedge clk);
            #1;
            pc_tr[k] = dut.pc;
            wd_tr[k] = dut.rfile_wd;
        end

        check("pc_c0", pc_tr[0], 32'h00);
        check("j_redirect_pc", pc_tr[3], 32'h40);
        check("nostall_pc_c5", pc_tr[5], 32'h48);
        check("nostall_pc_c6", pc_tr[6], 32'h4C);
        check("add_wb_wd", wd_tr[9], 32'd12);
        check("loaduse_pc_c10", pc_tr[10], 32'h5C);
        check("loaduse_hold_c11", pc_tr[11], 32'h5C);
        check("loaduse_resume_c12", pc_tr[12], 32'h60);
        check("beq_target_pc", pc_tr[17], 32'h74);
        check("bne_pc_c20", pc_tr[20], 32'h80);
        check("bne_nobubble_c21", pc_tr[21], 32'h84);

        check("r0", dut.RegFile.file_array[0], 32'h0);
        check("r3_add", dut.RegFile.file_array[3], 32'd12);
        check("r4_lw", dut.RegFile.file_array[4], 32'd10);
        check("r5_loaduse", dut.RegFile.file_array[5], 32'd20);
        check("r6", dut.RegFile.file_array[6], 32'h1234);
        check("r7_sw_lw", dut.RegFile.file_array[7], 32'h1234);
        check("r8_flushed", dut.RegFile.file_array[8], 32'h33);
        check("r9", dut.RegFile.file_array[9], 32'd1);
        check("r10_mfhi", dut.RegFile.file_array[10], 32'd1);
        check("r11_mflo", dut.RegFile.file_array[11], 32'hFFFF_FFFE);
        check("r12_slt", dut.RegFile.file_array[12], 32'd1);
        check("r13_sll", dut.RegFile.file_array[13], 32'd16);
        check("r14_after_bne", dut.RegFile.file_array[14], 32'h77);
        check("r15_unknown_nop", dut.RegFile.file_array[15], 32'h55);
        check("dm_word8", {dut.DatMem.mem_array[11], dut.DatMem.mem_array[10],
                           dut.DatMem.mem_array[9], dut.DatMem.mem_array[8]}, 32'h0000_000A);
        check("dm_byte16", {24'd0, dut.DatMem.mem_array[16]}, 32'h34);
        check("dm_byte17", {24'd0, dut.DatMem.mem_array[17]}, 32'h12);
        check("dm_byte18", {24'd0, dut.DatMem.mem_array[18]}, 32'h00);
        check("dm_byte19", {24'd0, dut.DatMem.mem_array[19]}, 32'h00);
        check("loop_pc_stable", pc_tr[47] & 32'hFFFF_FFF0, 32'hA0);

        // Mid-run reset: pc returns to 0 at the next edge, register file keeps contents.
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrun_reset_pc", dut.pc, 32'h0);
        check("midrun_reset_keeps_r3", dut.RegFile.file_array[3], 32'd12);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rerun_j_pc", dut.pc, 32'h40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_pipelined.md
# mips_pipelined

Five-stage (IF, ID, EX, MEM, WB) pipelined 32-bit MIPS subset CPU with integrated instruction memory, data memory and register file. It is the top-level processor core; the only external pins are clock and reset. Program, data and initial register contents are preloaded into the internal arrays by the environment before reset is released.

## Interface
- Parameters: none (memory depth fixed at 1024 bytes each).
- `clk`  input  1  single system clock; all state updates on rising edge.
- `rst`  input  1  reset is synchronous and active-high.
- Hierarchical names the bench depends on:
  - `InstrMem.mem_array` and `DatMem.mem_array`: 8-bit × 1024 byte arrays, little-endian words.
  - `RegFile.file_array`: 32 × 32-bit.
  - `pc`: current IF program counter.
  - `opcode`, `rs`, `rt`, `rd`, `shamt`, `funct`: fields of the instruction held in the IF/ID register.
  - `rfile_wd`: register-file write data in WB.

## Operation
- Instructions, with encodings:
  - R-type (opcode 0), by funct: ADD 32, SUB 34, AND 36, OR 37, SLT 42 (signed), SLL 0 (rd = rt << shamt; all-zero word = NOP), MULTU 25, MFHI 10, MFLO 12.
  - I-type / J-type, by opcode: ADDIU 9, LW 35, SW 43, BEQ 4, BNE 5, J 2.
- Arithmetic: ADD, SUB and ADDIU wrap modulo 2^32, with no overflow exceptions. ADDIU, LW, SW, BEQ and BNE sign-extend imm16.
- MULTU: unsigned 32×32 → 64-bit product; HI = [63:32], LO = [31:0].
- Memory: addresses are byte addresses; word = {m[a+3], m[a+2], m[a+1], m[a]}. Word-aligned access only; low 2 address bits are ignored.
- Effective address = rs + signext(imm).
- Branch target = PC+4 + (signext(imm) << 2).
- J target = {PC+4[31:28], imm26, 2'b00}.
- Register $0 always reads 0; writes to it are discarded.
- Unrecognised opcode/funct executes as NOP: no register, memory or HI/LO write.

## Timing
- Reset (synchronous, active-high):
  - `pc` = 0; HI = LO = 0.
  - IF/ID, ID/EX, EX/MEM and MEM/WB are loaded with NOP (all control signals deasserted).
  - Memories and register file are not cleared.
- Fetch: one instruction per cycle; `pc` += 4 each cycle unless stalled or redirected.
- Write-back: an instruction fetched in cycle n writes the register file at the end of cycle n+4.
- Register file: write occurs before read in the same cycle, so ID sees a same-cycle WB value.
- Forwarding to EX operands, EX/MEM result prioritised over MEM/WB result. Back-to-back ALU dependencies incur no stall.
- Load-use hazard: LW in EX whose rt matches rs/rt of the instruction in ID:
  - stall 1 cycle; hold `pc` and IF/ID, insert NOP into ID/EX;
  - LW data then reaches the dependent instruction via MEM/WB forwarding.
- HI/LO:
  - written at the clock edge ending MULTU's EX cycle;
  - MFHI/MFLO read HI/LO in EX, so an MFHI immediately after MULTU sees the new value;
  - MFHI/MFLO write rd through the normal pipeline.
- J: resolved in ID. `pc` is redirected at the next edge and the IF/ID instruction is flushed to NOP (1 bubble).
- BEQ/BNE:
  - compare forwarded operands in EX;
  - if taken, `pc` = target at the next edge and IF/ID and ID/EX are flushed to NOP (2 bubbles);
  - if not taken, no penalty.
- Simultaneous events: a taken branch in EX overrides a J in ID and overrides a load-use stall.
- SW: stores the forwarded rt value in MEM at the clock edge.
- Reset asserted mid-program: state returns to the reset values at the next edge; in-flight instructions are discarded and have no further writes.

## Test plan
- Reset, then `ADDIU $1,$0,5 ; ADDIU $2,$0,7 ; ADD $3,$1,$2` → $3 = 12 with no stall cycles; `rfile_wd` = 12 in the ADD's WB cycle.
- Data memory word 0x8 = 0x0000000A; `LW $4,8($0) ; ADD $5,$4,$4` → one stall (`pc` held one cycle), then $5 = 20.
- `ADDIU $6,$0,0x1234 ; SW $6,16($0) ; LW $7,16($0)`:
  - DatMem bytes 16..19 = 34 12 00 00;
  - $7 = 0x1234.
- `BEQ $0,$0,+2` followed by two ADDIUs to $8, then `ADDIU $9,$0,1`:
  - $8 is never written, $9 = 1;
  - BNE $0,$0 is not taken and incurs no bubble.
- $1 = 0xFFFFFFFF, $2 = 2:
  - `MULTU $1,$2 ; MFHI $10 ; MFLO $11` → $10 = 1, $11 = 0xFFFFFFFE;
  - `SLT $12,$1,$2` → 1;
  - `SLL $13,$2,3` → 16.
- `J` to 0x40 → the instruction after J is flushed and `pc` = 0x40 the next cycle. Asserting `rst` mid-run returns `pc` to 0 at the next edge.
